exe_mem_stage_skid: RTL and testbench

- Parametrised EXE->MEM pipeline stage: the next-generation replacement for the fixed free-running EXE/MEM latch.
- Adds a valid/ready handshake, so MEM stalls back-pressure EXE without losing a beat.
- A 2-entry skid buffer keeps in_ready a pure register output, cutting the combinational stall path.
- Adds a synchronous flush for branch/exception squash and bubble-safe control outputs.

---
 rtl/exe_mem_stage_skid.sv | 129 ++++++++++++
 tb/tb_exe_mem_stage_skid.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_stage_skid.sv
// EXE->MEM pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
// in_ready and occupancy are registered, so MEM back-pressure never reaches EXE combinationally.
module exe_mem_stage_skid #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned DST_W         = 5,
  parameter int unsigned CTRL_W        = 9,
  parameter int unsigned WE_BIT        = 3,
  parameter bit          ZERO_DST_KILL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_store,
  input  logic [DST_W-1:0]  in_dst,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store,
  output logic [DST_W-1:0]  out_dst,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  localparam int unsigned PayW = 2 * DATA_W + DST_W + CTRL_W;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PayW-1:0]   main_q, main_d;
  logic [PayW-1:0]   skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        occ_q, occ_d;
  logic [CTRL_W-1:0] cap_ctrl;
  logic [PayW-1:0]   in_pay;
  logic              valid_int;
  logic              acc;
  logic              drn;

  // Writes to r0 are dropped at capture so MEM/WB never see a live enable for them.
  always_comb begin
    cap_ctrl = in_ctrl;
    if (ZERO_DST_KILL && (in_dst == '0)) begin
      cap_ctrl[WE_BIT] = 1'b0;
    end
  end

  assign in_pay    = {in_result, in_store, in_dst, cap_ctrl};
  assign valid_int = (state_q != StEmpty);
  assign acc       = in_valid & in_ready_q;
  assign drn       = valid_int & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (acc) begin
            main_d  = in_pay;
            state_d = StOne;
          end
        end
        StOne: begin
          if (acc && drn) begin
            main_d = in_pay;
          end else if (acc) begin
            skid_d  = in_pay;
            state_d = StFull;
          end else if (drn) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (drn) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    in_ready_d = (state_d != StFull);
    case (state_d)
      StOne:   occ_d = 2'd1;
      StFull:  occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      occ_q      <= occ_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign occupancy  = occ_q;
  assign out_valid  = valid_int;
  assign out_result = main_q[PayW-1 -: DATA_W];
  assign out_store  = main_q[DST_W + CTRL_W +: DATA_W];
  assign out_dst    = main_q[CTRL_W +: DST_W];
  // Bubbles carry no control, so no write can fire from an empty stage.
  assign out_ctrl   = valid_int ? main_q[CTRL_W-1:0] : '0;

endmodule

// File: tb/tb_exe_mem_stage_skid.sv
// Self-checking bench: a queue model of the stage checked every cycle, plus directed literals.
module tb_exe_mem_stage_skid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic [31:0] in_store = '0;
  logic [4:0]  in_dst = '0;
  logic [8:0]  in_ctrl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [31:0] out_store;
  logic [4:0]  out_dst;
  logic [8:0]  out_ctrl;
  logic [1:0]  occupancy;

  exe_mem_stage_skid dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_store   (in_store),
    .in_dst     (in_dst),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_store  (out_store),
    .out_dst    (out_dst),
    .out_ctrl   (out_ctrl),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  dst;
    logic [8:0]  ctrl;
  } beat_t;

  beat_t q[$];
  int    tests = 0;
  int    fails = 0;
  int    drained = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of depth 2; acceptance uses the model's own fullness, not the DUT's in_ready.
  always @(posedge clk or negedge rst_n) begin
    beat_t b;
    bit    acc;
    bit    drn;
    if (!rst_n) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      b.result = in_result;
      b.store  = in_store;
      b.dst    = in_dst;
      b.ctrl   = (in_dst == 5'd0) ? (in_ctrl & ~9'h008) : in_ctrl;
      if (drn) drained++;
      if (flush) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(b);
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    chk("occupancy", {62'd0, occupancy}, 64'(q.size()));
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    if (q.size() != 0) begin
      chk("result", {32'd0, out_result}, {32'd0, q[0].result});
      chk("store", {32'd0, out_store}, {32'd0, q[0].store});
      chk("dst", {59'd0, out_dst}, {59'd0, q[0].dst});
      chk("ctrl", {55'd0, out_ctrl}, {55'd0, q[0].ctrl});
    end else begin
      chk("bubble_ctrl", {55'd0, out_ctrl}, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] d,
                       input logic [8:0] c);
    in_valid  = v;
    in_result = r;
    in_store  = ~r;
    in_dst    = d;
    in_ctrl   = c;
  endtask

  initial begin
    int base;
    #12;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_occ", {62'd0, occupancy}, 64'd0);
    chk("rst_ctrl", {55'd0, out_ctrl}, 64'd0);
    chk("rst_result", {32'd0, out_result}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Streaming
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h10 + 32'(i), 5'd1, 9'(i));
      tick();
      chk("stream_result", {32'd0, out_result}, {32'd0, 32'h10 + 32'(i)});
      chk("stream_ready", {63'd0, in_ready}, 64'd1);
      chk("stream_occ", {62'd0, occupancy}, 64'd1);
    end
    drive(1'b0, '0, '0, '0);
    tick();

    // Stall fill
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd2, 9'h001);
    tick();
    chk("fill1_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 32'hB, 5'd2, 9'h002);
    tick();
    chk("fill2_ready", {63'd0, in_ready}, 64'd0);
    chk("fill2_occ", {62'd0, occupancy}, 64'd2);
    chk("fill2_result", {32'd0, out_result}, 64'hA);
    drive(1'b0, '0, '0, '0);
    tick();
    chk("stall_hold", {32'd0, out_result}, 64'hA);
    out_ready = 1'b1;
    tick();
    chk("drain_b", {32'd0, out_result}, 64'hB);
    chk("drain_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("drain_empty", {63'd0, out_valid}, 64'd0);

    // Flush in FULL with a beat offered
    out_ready = 1'b0;
    drive(1'b1, 32'h1, 5'd3, 9'h1FF);
    tick();
    drive(1'b1, 32'h2, 5'd3, 9'h1FF);
    tick();
    drive(1'b1, 32'hC, 5'd3, 9'h1FF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_ctrl", {55'd0, out_ctrl}, 64'd0);
    chk("flush_occ", {62'd0, occupancy}, 64'd0);
    chk("flush_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    tick();
    chk("flush_no_c", {63'd0, out_valid}, 64'd0);
    // Flush in ONE while a new beat is accepted: both vanish
    drive(1'b1, 32'h3, 5'd3, 9'h001);
    out_ready = 1'b0;
    tick();
    drive(1'b1, 32'hD, 5'd3, 9'h001);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("flush1_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    tick();

    // Zero-dst kill
    drive(1'b1, 32'h20, 5'd0, 9'h1FF);
    tick();
    chk("kill_ctrl", {55'd0, out_ctrl}, 64'h1F7);
    drive(1'b1, 32'h21, 5'd5, 9'h1FF);
    tick();
    chk("nokill_ctrl", {55'd0, out_ctrl}, 64'h1FF);
    drive(1'b0, '0, '0, '0);
    tick();

    // Async reset between edges
    drive(1'b1, 32'h30, 5'd7, 9'h0FF);
    tick();
    drive(1'b1, 32'h31, 5'd7, 9'h0FF);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_ctrl", {55'd0, out_ctrl}, 64'd0);
    chk("arst_occ", {62'd0, occupancy}, 64'd0);
    chk("arst_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_result", {32'd0, out_result}, 64'd0);
    drive(1'b0, '0, '0, '0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b1, 32'h55, 5'd9, 9'h003);
    tick();
    chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("post_rst_result", {32'd0, out_result}, 64'h55);
    drive(1'b0, '0, '0, '0);
    tick();

    // Random valid/ready with occasional flush
    base = drained;
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 3)), 9'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("rand_progress", {63'd0, (drained - base) > 2000}, 64'd1);
    chk("rand_empty", {63'd0, out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
